// File: rtl/vreg_pipe_trace_pkg.sv
// Shared sizing helpers for the traced elastic register pipeline.
// Width of the occupancy count and layout of the ASCII line trace.
package vreg_pipe_trace_pkg;

    localparam int TRACE_PFX = 4;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int fld_w(input int nbits);
        return (nbits + 3) / 4;
    endfunction

    // "p = " prefix, one hex field per stage, "|" between stages
    function automatic int trace_len(input int nbits, input int nst);
        return TRACE_PFX + nst * fld_w(nbits) + nst - 1;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h57 + {4'b0, n});
    endfunction

endpackage

// File: rtl/vreg_pipe_trace_if.sv
// Enqueue/dequeue val/rdy handshake bundle for the traced pipeline.
// master drives messages and deq_rdy; slave is the pipeline.
interface vreg_pipe_trace_if #(
    parameter int NBITS = 32
);
    logic             enq_val;
    logic             enq_rdy;
    logic [NBITS-1:0] enq_msg;
    logic             deq_val;
    logic             deq_rdy;
    logic [NBITS-1:0] deq_msg;

    modport master (
        output enq_val, enq_msg, deq_rdy,
        input  enq_rdy, deq_val, deq_msg
    );

    modport slave (
        input  enq_val, enq_msg, deq_rdy,
        output enq_rdy, deq_val, deq_msg
    );
endinterface

// File: rtl/vreg_pipe_stage.sv
// One pipeline slot: valid bit plus data register.
// Flush dominates load, load dominates drop.
module vreg_pipe_stage #(
    parameter int               NBITS       = 32,
    parameter logic [NBITS-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             drop_i,
    input  logic [NBITS-1:0] d_i,
    output logic             v_o,
    output logic [NBITS-1:0] d_o
);
    logic             v_q, v_d;
    logic [NBITS-1:0] d_q, d_d;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            v_d = 1'b0;
            d_d = RESET_VALUE;
        end else if (load_i) begin
            v_d = 1'b1;
            d_d = d_i;
        end else if (drop_i) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VALUE;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;
endmodule

// File: rtl/vreg_pipe_trace.sv
// Elastic NSTAGES-deep register pipeline with bubble collapse,
// backpressure, synchronous flush and an ASCII per-stage line trace.
module vreg_pipe_trace
    import vreg_pipe_trace_pkg::*;
#(
    parameter int               NBITS       = 32,
    parameter int               NSTAGES     = 3,
    parameter logic [NBITS-1:0] RESET_VALUE = '0,
    localparam int              CW          = cnt_w(NSTAGES),
    localparam int              FW          = fld_w(NBITS),
    localparam int              TL          = trace_len(NBITS, NSTAGES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    vreg_pipe_trace_if.slave    pipe,
    output logic [CW-1:0]       count,
    output logic [8*TL-1:0]     trace
);
    logic [NSTAGES-1:0] v;
    logic [NSTAGES-1:0] go;
    logic [NSTAGES-1:0] load;
    logic [NBITS-1:0]   d [NSTAGES];
    logic [4*FW-1:0]    dp;

    // Ready flows back from the output end within one cycle
    always_comb begin
        go = '0;
        go[NSTAGES-1] = v[NSTAGES-1] & pipe.deq_rdy;
        for (int i = NSTAGES - 2; i >= 0; i--) begin
            go[i] = v[i] & (~v[i+1] | go[i+1]);
        end
    end

    assign pipe.enq_rdy = ~clear & (~v[0] | go[0]);
    assign pipe.deq_val = v[NSTAGES-1];
    assign pipe.deq_msg = d[NSTAGES-1];

    always_comb begin
        load = '0;
        load[0] = pipe.enq_val & pipe.enq_rdy;
        for (int i = 1; i < NSTAGES; i++) begin
            load[i] = go[i-1];
        end
    end

    for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
        logic [NBITS-1:0] din;
        if (g == 0) begin : g_head
            assign din = pipe.enq_msg;
        end else begin : g_body
            assign din = d[g-1];
        end
        vreg_pipe_stage #(
            .NBITS       (NBITS),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush_i (clear),
            .load_i  (load[g]),
            .drop_i  (go[g]),
            .d_i     (din),
            .v_o     (v[g]),
            .d_o     (d[g])
        );
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            count = count + CW'(v[i]);
        end
    end

    // Leftmost character sits in the most significant byte
    always_comb begin
        trace = '0;
        dp    = '0;
        trace[8*TL-1 -: 8*TRACE_PFX] = "p = ";
        for (int i = 0; i < NSTAGES; i++) begin
            dp = '0;
            dp[NBITS-1:0] = d[i];
            for (int j = 0; j < FW; j++) begin
                trace[8*(TL-(TRACE_PFX+i*(FW+1)+j))-1 -: 8] =
                    v[i] ? hex_chr(dp[4*(FW-1-j) +: 4]) : 8'h2e;
            end
            if (i < NSTAGES - 1) begin
                trace[8*(TL-(TRACE_PFX+i*(FW+1)+FW))-1 -: 8] = 8'h7c;
            end
        end
    end
endmodule

// File: tb/tb_vreg_pipe_trace.sv
// Scoreboard bench for vreg_pipe_trace (NSTAGES=3, NBITS=32).
// Stimulus pushes expected deliveries; a negedge monitor pops them.
module tb_vreg_pipe_trace;
    import vreg_pipe_trace_pkg::*;

    localparam int NB = 32;
    localparam int NS = 3;
    localparam int CW = cnt_w(NS);
    localparam int TL = trace_len(NB, NS);

    typedef struct {
        logic [NB-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic [CW-1:0] count;
    logic [8*TL-1:0] trace;
    logic [8*TL-1:0] exp_tr;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    exp_t sb[$];

    vreg_pipe_trace_if #(.NBITS(NB)) pipe ();

    vreg_pipe_trace #(
        .NBITS       (NB),
        .NSTAGES     (NS),
        .RESET_VALUE ('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .pipe  (pipe.slave),
        .count (count),
        .trace (trace)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    task automatic chk_tr(input string nm, input logic [8*TL-1:0] req);
        n_tests++;
        if (trace !== req) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", nm, trace, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NB-1:0] dt, input int c);
        exp_t e;
        e.data = dt;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!reset && pipe.deq_val && pipe.deq_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_deq", 64'(pipe.deq_msg), 64'hx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deq_msg", 64'(pipe.deq_msg), 64'(e.data));
                if (e.cyc >= 0) chk("deq_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        pipe.enq_val = 1'b0;
        pipe.enq_msg = '0;
        pipe.deq_rdy = 1'b0;

        // Reset state
        #1;
        chk("rst_enq_rdy", 64'(pipe.enq_rdy), 64'd1);
        chk("rst_deq_val", 64'(pipe.deq_val), 64'd0);
        chk("rst_deq_msg", 64'(pipe.deq_msg), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single item latency and trace
        pipe.deq_rdy = 1'b1;
        pipe.enq_val = 1'b1;
        pipe.enq_msg = 32'h0000_00ab;
        push(32'h0000_00ab, cyc + 3);
        tick();
        pipe.enq_val = 1'b0;
        #1;
        exp_tr = "p = 000000ab|........|........";
        chk_tr("trace_c1", exp_tr);
        repeat (4) tick();

        // Back-to-back stream
        for (int k = 0; k < 10; k++) begin
            pipe.enq_val = 1'b1;
            pipe.enq_msg = 32'(k);
            #1;
            chk("stream_enq_rdy", 64'(pipe.enq_rdy), 64'd1);
            push(32'(k), cyc + 3);
            tick();
        end
        pipe.enq_val = 1'b0;
        repeat (4) tick();

        // Backpressure: fill, then release for one cycle
        pipe.deq_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pipe.enq_val = 1'b1;
            pipe.enq_msg = 32'h100 + 32'(k);
            #1;
            chk("bp_enq_rdy", 64'(pipe.enq_rdy), 64'd1);
            push(32'h100 + 32'(k), -1);
            tick();
        end
        pipe.enq_msg = 32'h103;
        #1;
        chk("full_enq_rdy", 64'(pipe.enq_rdy), 64'd0);
        chk("full_count", 64'(count), 64'd3);
        pipe.deq_rdy = 1'b1;
        #1;
        chk("pass_enq_rdy", 64'(pipe.enq_rdy), 64'd1);
        push(32'h103, -1);
        tick();
        pipe.deq_rdy = 1'b0;
        pipe.enq_val = 1'b0;
        #1;
        chk("pass_count", 64'(count), 64'd3);
        pipe.deq_rdy = 1'b1;
        repeat (4) tick();
        chk("drain_count", 64'(count), 64'd0);

        // Bubble collapse
        pipe.deq_rdy = 1'b0;
        pipe.enq_val = 1'b1;
        pipe.enq_msg = 32'h1;
        tick();
        pipe.enq_val = 1'b0;
        tick();
        pipe.enq_val = 1'b1;
        pipe.enq_msg = 32'h2;
        tick();
        pipe.enq_val = 1'b0;
        repeat (2) tick();
        chk("bub_count", 64'(count), 64'd2);
        chk("bub_deq_msg", 64'(pipe.deq_msg), 64'h1);
        exp_tr = "p = ........|00000002|00000001";
        chk_tr("bub_trace", exp_tr);
        push(32'h1, -1);
        push(32'h2, -1);
        pipe.deq_rdy = 1'b1;
        repeat (3) tick();

        // Clear beats a simultaneous enqueue
        pipe.deq_rdy = 1'b0;
        pipe.enq_val = 1'b1;
        pipe.enq_msg = 32'ha1;
        tick();
        pipe.enq_msg = 32'ha2;
        tick();
        pipe.enq_val = 1'b0;
        tick();
        chk("pre_clr_count", 64'(count), 64'd2);
        clear = 1'b1;
        pipe.enq_val = 1'b1;
        pipe.enq_msg = 32'hdead;
        #1;
        chk("clr_enq_rdy", 64'(pipe.enq_rdy), 64'd0);
        tick();
        clear = 1'b0;
        pipe.enq_val = 1'b0;
        #1;
        chk("clr_count", 64'(count), 64'd0);
        chk("clr_deq_val", 64'(pipe.deq_val), 64'd0);
        chk("clr_deq_msg", 64'(pipe.deq_msg), 64'd0);
        pipe.deq_rdy = 1'b1;
        repeat (3) tick();

        // Asynchronous reset with items in flight
        pipe.deq_rdy = 1'b0;
        pipe.enq_val = 1'b1;
        pipe.enq_msg = 32'hc1;
        tick();
        pipe.enq_msg = 32'hc2;
        tick();
        pipe.enq_val = 1'b0;
        repeat (2) tick();
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_deq_val", 64'(pipe.deq_val), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_deq_val", 64'(pipe.deq_val), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_deq_msg", 64'(pipe.deq_msg), 64'd0);
        chk("arst_enq_rdy", 64'(pipe.enq_rdy), 64'd1);
        tick();
        reset = 1'b0;
        pipe.deq_rdy = 1'b1;
        repeat (3) tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
